psum_accumulator: RTL and testbench
===================================

PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 SHALL have parameter OC2_LANES, default 16: lanes per partial beat; must match the upstream conv core.
REQ-002 SHALL have parameter ACC_W, default 32: signed width of partials and accumulators.
REQ-003 SHALL have parameter CNT_W, default 16: width of the tile and pixel counters.
REQ-004 SHALL use one clock and an asynchronous active-low reset, with ports as follows:
- clk  in  1  sole clock; all state changes on rising edge.
- rst_n  in  1  asynchronous assert, active-low.
- start  in  1  single-cycle job start; sampled only in IDLE.
- num_tiles  in  CNT_W  partials per output pixel; latched at start.
- num_pix  in  CNT_W  output pixels per job; latched at start.
- in_valid  in  1  upstream partial beat valid.
- in_ready  out  1  beat accepted when in_valid and in_ready are both high.
- in_partial  in  signed ACC_W x OC2_LANES  upstream partial sums.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result beat.
- out_data  out  signed ACC_W x OC2_LANES  accumulated pixel result.
- out_last  out  1  high with the final pixel beat of the job.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse at job completion.
- ovf  out  1  sticky saturation flag; cleared at start.

Function
REQ-005 SHALL implement three states: IDLE, ACCUM and EMIT.
REQ-006 IDLE: start=1 latches num_tiles and num_pix, clears the accumulators, tile_cnt, pix_cnt and ovf, and moves to ACCUM on the next cycle.
REQ-007 start with num_pix=0 SHALL stay in IDLE and pulse done exactly once on the next cycle.
REQ-008 num_tiles=0 SHALL be treated as 1.
REQ-009 in_ready SHALL equal (state==ACCUM); it is combinational from state only and never depends on in_valid.
REQ-010 Each ACCUM handshake SHALL, per lane, compute acc + in_partial saturated to [-2^(ACC_W-1), 2^(ACC_W-1)-1], and increment tile_cnt.
REQ-011 Any saturation event on any lane SHALL set ovf, which then holds until the next accepted start.
REQ-012 A handshake with tile_cnt==num_tiles-1 SHALL load the saturated sum into out_data, reset tile_cnt, and enter EMIT.
- out_valid rises the cycle after the last partial is accepted (latency 1).
REQ-013 EMIT: out_valid=1; out_data and out_last SHALL hold stable until out_ready=1.
- out_last = (pix_cnt==num_pix-1).
REQ-014 EMIT handshake, not last pixel: SHALL increment pix_cnt, clear the accumulators, return to ACCUM, and drop out_valid.
REQ-015 EMIT handshake, last pixel: SHALL return to IDLE and pulse done in the same cycle as the transition.
REQ-016 start outside IDLE SHALL be ignored, with no effect on state, counters or latched configuration.
REQ-017 Throughput SHALL be one pixel per num_tiles+1 cycles with continuous in_valid and out_ready; there are no bubbles beyond the EMIT cycle.
REQ-018 in_partial SHALL be ignored whenever in_ready=0.

Reset
REQ-019 rst_n=0 SHALL immediately force:
- state=IDLE;
- out_valid, out_last, done, ovf and busy = 0;
- out_data, accumulators, tile_cnt and pix_cnt = 0.
REQ-020 Reset mid-job SHALL abandon the job with no done pulse; operation resumes only on a new start after deassertion.

Structure
REQ-021 OC2_LANES, ACC_W and the state enum type SHALL live in the shared conv package, reused by the conv core and this block.
REQ-022 Per-lane saturating addition SHALL be one sub-module, sat_add_s, instantiated OC2_LANES times; the FSM and counters are in psum_accumulator.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Basic: num_tiles=3, num_pix=1; lane0 partials 5, -2, 10 -> out_data[0]=13 one cycle after the third beat; out_last=1, done pulses once.
- Multi-pixel with backpressure: num_tiles=2, num_pix=3, out_ready held low for 4 cycles per pixel -> 3 results with stable data while stalled; in_ready=0 during EMIT; out_last only on the 3rd beat.
- Saturation: ACC_W=32, partials 0x7FFFFFF0 then 0x00000100 -> out_data=0x7FFFFFFF, ovf=1; ovf cleared by the next start.
- Edge counts: num_tiles=0 -> behaves as 1 (each partial emitted directly); num_pix=0 -> done one cycle after start, busy never rises.
- Mid-job abuse: start asserted during ACCUM is ignored; rst_n pulsed mid-job -> all outputs 0 asynchronously, no done; a fresh job afterwards completes correctly.
- Random in_valid/out_ready gaps over 100 jobs: results SHALL match a reference sum per lane.

Source files
------------

// File: rtl/psum_accumulator_pkg.sv
// ---------------------------------------------------------------------------
// psum_accumulator_pkg
// Shared conv package: lane count, accumulator width and counter width used
// by the conv core and the partial-sum accumulator, plus the accumulator
// state enum.
// No ports (package).
// ---------------------------------------------------------------------------
package psum_accumulator_pkg;

  // Lanes per partial beat; the conv core produces this many sums per beat.
  localparam int OC2_LANES = 16;

  // Signed width of every partial sum and accumulator.
  localparam int ACC_W = 32;

  // Width of the tile and pixel counters.
  localparam int CNT_W = 16;

  // Accumulator controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_EMIT  = 2'd2
  } acc_state_e;

endpackage

// File: rtl/psum_accumulator_sat_add_s.sv
// ---------------------------------------------------------------------------
// sat_add_s
// One lane of signed saturating addition. The sum is clamped to
// [-2^(W-1), 2^(W-1)-1] and o_sat flags that clamping happened.
// Ports:
//   i_a    in  W  signed accumulator value
//   i_b    in  W  signed partial sum
//   o_sum  out W  saturated sum
//   o_sat  out 1  high when the true sum was out of range
// ---------------------------------------------------------------------------
module sat_add_s
  import psum_accumulator_pkg::*;
#(
  parameter int W = ACC_W
) (
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  output logic signed [W-1:0] o_sum,
  output logic                o_sat
);

  localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

  logic signed [W:0] w_wide;

  // Add with one guard bit so the true sum is always representable.
  assign w_wide = {i_a[W-1], i_a} + {i_b[W-1], i_b};

  // Overflow shows up as the guard bit disagreeing with the result sign bit;
  // the guard bit then carries the true sign, which picks the clamp rail.
  assign o_sat = w_wide[W] ^ w_wide[W-1];
  assign o_sum = !o_sat     ? w_wide[W-1:0] :
                 w_wide[W]  ? SAT_MIN       : SAT_MAX;

endmodule

// File: rtl/psum_accumulator.sv
// ---------------------------------------------------------------------------
// psum_accumulator
// Sums num_tiles partial-sum beats per output pixel (per lane, saturating)
// and emits one result beat per pixel, num_pix pixels per job.
// Ports:
//   clk          in  1               sole clock, rising edge
//   rst_n        in  1               asynchronous active-low reset
//   i_start      in  1               job start, sampled only in IDLE
//   i_numTiles   in  CNT_W           partials per pixel (0 treated as 1)
//   i_numPix     in  CNT_W           pixels per job (0 = empty job)
//   i_inValid    in  1               partial beat valid
//   o_inReady    out 1               high only in ACCUM
//   i_inPartial  in  LANES x ACC_W   signed partial sums
//   o_outValid   out 1               result beat valid (EMIT)
//   i_outReady   in  1               downstream accepts result
//   o_outData    out LANES x ACC_W   accumulated pixel result
//   o_outLast    out 1               final pixel beat of the job
//   o_busy       out 1               state is not IDLE
//   o_done       out 1               one-cycle completion pulse
//   o_ovf        out 1               sticky saturation flag
// ---------------------------------------------------------------------------
module psum_accumulator #(
  parameter int OC2_LANES = psum_accumulator_pkg::OC2_LANES,
  parameter int ACC_W     = psum_accumulator_pkg::ACC_W,
  parameter int CNT_W     = psum_accumulator_pkg::CNT_W
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_start,
  input  logic [CNT_W-1:0]                 i_numTiles,
  input  logic [CNT_W-1:0]                 i_numPix,
  input  logic                             i_inValid,
  output logic                             o_inReady,
  input  logic [OC2_LANES-1:0][ACC_W-1:0]  i_inPartial,
  output logic                             o_outValid,
  input  logic                             i_outReady,
  output logic [OC2_LANES-1:0][ACC_W-1:0]  o_outData,
  output logic                             o_outLast,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_ovf
);

  import psum_accumulator_pkg::*;

  acc_state_e r_state;
  acc_state_e w_nextState;

  logic [CNT_W-1:0] r_lastTile;
  logic [CNT_W-1:0] r_lastPix;
  logic [CNT_W-1:0] r_tileCnt;
  logic [CNT_W-1:0] r_pixCnt;

  logic [OC2_LANES-1:0][ACC_W-1:0] r_acc;
  logic [OC2_LANES-1:0][ACC_W-1:0] w_sum;
  logic [OC2_LANES-1:0][ACC_W-1:0] r_outData;
  logic [OC2_LANES-1:0]            w_laneSat;

  logic w_jobStart;
  logic w_emptyJob;
  logic w_inFire;
  logic w_outFire;
  logic w_tileDone;
  logic w_pixDone;
  logic r_done;
  logic r_ovf;

  // Handshakes are qualified by state alone, so partials are ignored
  // whenever o_inReady is low, and a start outside IDLE never registers.
  assign w_jobStart = i_start && (r_state == ST_IDLE);
  assign w_emptyJob = (i_numPix == '0);
  assign w_inFire   = i_inValid && (r_state == ST_ACCUM);
  assign w_outFire  = i_outReady && (r_state == ST_EMIT);
  assign w_tileDone = (r_tileCnt == r_lastTile);
  assign w_pixDone  = (r_pixCnt == r_lastPix);

  // One saturating adder per lane: accumulator plus the incoming partial.
  for (genvar g = 0; g < OC2_LANES; g++) begin : g_lane
    sat_add_s #(
      .W (ACC_W)
    ) u_satAdd (
      .i_a   (r_acc[g]),
      .i_b   (i_inPartial[g]),
      .o_sum (w_sum[g]),
      .o_sat (w_laneSat[g])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. An empty job (num_pix=0) never leaves IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_start && !w_emptyJob) begin
          w_nextState = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (w_inFire && w_tileDone) begin
          w_nextState = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (w_outFire) begin
          w_nextState = w_pixDone ? ST_IDLE : ST_ACCUM;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Job configuration is held as last-index values so the counters compare
  // directly; num_tiles=0 collapses to a single tile per pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lastTile <= '0;
      r_lastPix  <= '0;
    end else if (w_jobStart) begin
      r_lastTile <= (i_numTiles == '0) ? '0 : i_numTiles - 1'b1;
      r_lastPix  <= i_numPix - 1'b1;
    end
  end

  // Tile counter wraps on the last partial of a pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tileCnt <= '0;
    end else if (w_jobStart) begin
      r_tileCnt <= '0;
    end else if (w_inFire) begin
      r_tileCnt <= w_tileDone ? '0 : r_tileCnt + 1'b1;
    end
  end

  // Pixel counter advances on each non-final result handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pixCnt <= '0;
    end else if (w_jobStart) begin
      r_pixCnt <= '0;
    end else if (w_outFire && !w_pixDone) begin
      r_pixCnt <= r_pixCnt + 1'b1;
    end
  end

  // Accumulators clear at job start and once a result is taken, so each
  // pixel starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_jobStart || w_outFire) begin
      r_acc <= '0;
    end else if (w_inFire) begin
      r_acc <= w_sum;
    end
  end

  // Result register captures the final saturated sum and then holds
  // through any downstream stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outData <= '0;
    end else if (w_inFire && w_tileDone) begin
      r_outData <= w_sum;
    end
  end

  // Sticky saturation flag, cleared only by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_jobStart) begin
      r_ovf <= 1'b0;
    end else if (w_inFire && (|w_laneSat)) begin
      r_ovf <= 1'b1;
    end
  end

  // Done is registered so it appears in the first IDLE cycle after the
  // final handshake, or the cycle after an empty-job start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= (w_jobStart && w_emptyJob) || (w_outFire && w_pixDone);
    end
  end

  // Handshake and status outputs decode state only, so an asynchronous
  // reset drops them immediately.
  assign o_inReady  = (r_state == ST_ACCUM);
  assign o_outValid = (r_state == ST_EMIT);
  assign o_outLast  = (r_state == ST_EMIT) && w_pixDone;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_outData  = r_outData;
  assign o_done     = r_done;
  assign o_ovf      = r_ovf;

endmodule

// File: tb/tb_psum_accumulator.sv
// ---------------------------------------------------------------------------
// tb_psum_accumulator
// Directed and randomised-gap bench for psum_accumulator (16 lanes x 32 bit).
// Inputs change on the falling edge; outputs are observed on the falling
// edge, half a period away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_psum_accumulator;

  localparam int LANES = 16;
  localparam int W     = 32;
  localparam int CW    = 16;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      start;
  logic [CW-1:0]             numTiles;
  logic [CW-1:0]             numPix;
  logic                      inValid;
  logic                      inReady;
  logic [LANES-1:0][W-1:0]   inPartial;
  logic                      outValid;
  logic                      outReady;
  logic [LANES-1:0][W-1:0]   outData;
  logic                      outLast;
  logic                      busy;
  logic                      done;
  logic                      ovf;

  int checks   = 0;
  int failures = 0;

  psum_accumulator #(
    .OC2_LANES (LANES),
    .ACC_W     (W),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (start),
    .i_numTiles  (numTiles),
    .i_numPix    (numPix),
    .i_inValid   (inValid),
    .o_inReady   (inReady),
    .i_inPartial (inPartial),
    .o_outValid  (outValid),
    .i_outReady  (outReady),
    .o_outData   (outData),
    .o_outLast   (outLast),
    .o_busy      (busy),
    .o_done      (done),
    .o_ovf       (ovf)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  // Hard stop in case something upstream of every bounded wait goes wrong.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  // Start a job; returns at the falling edge after start was sampled.
  task automatic start_job(input logic [CW-1:0] t, input logic [CW-1:0] n);
    start    = 1'b1;
    numTiles = t;
    numPix   = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one partial beat and hold it until it is accepted (bounded).
  task automatic send_beat(input logic [LANES-1:0][W-1:0] p);
    int n;
    inValid   = 1'b1;
    inPartial = p;
    n = 0;
    while (!inReady && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (inReady !== 1'b1) begin
      failures++;
      $display("[TB] FAIL beat_accept_timeout inReady=%b required=1", inReady);
    end
    @(negedge clk);
    inValid   = 1'b0;
    inPartial = '0;
  endtask

  // Take the current result beat (one handshake cycle).
  task automatic take_result();
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, inReady, outValid, outLast, done, ovf} !== 6'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags got=%b required=000000",
               {busy, inReady, outValid, outLast, done, ovf});
    end
    checks++;
    if (outData !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outData got=%h required=0", outData);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [LANES-1:0][W-1:0] p;
    int doneSeen;
    start_job(16'd3, 16'd1);
    checks++;
    if ({busy, inReady, outValid} !== 3'b110) begin
      failures++;
      $display("[TB] FAIL basic_enter_accum got=%b required=110", {busy, inReady, outValid});
    end
    p = '0; p[0] = 32'd5;          p[7] = 32'd100;
    send_beat(p);
    p = '0; p[0] = 32'hFFFF_FFFE;  p[7] = 32'd200;
    send_beat(p);
    checks++;
    if (outValid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_early_valid got=%b required=0", outValid);
    end
    p = '0; p[0] = 32'd10;         p[7] = 32'hFFFF_FFFF;
    send_beat(p);
    checks++;
    if ({outValid, outLast, inReady} !== 3'b110) begin
      failures++;
      $display("[TB] FAIL basic_emit_flags got=%b required=110", {outValid, outLast, inReady});
    end
    checks++;
    if (outData[0] !== 32'd13 || outData[7] !== 32'd299 || outData[1] !== 32'd0) begin
      failures++;
      $display("[TB] FAIL basic_data lane0=%0d lane7=%0d lane1=%0d required=13/299/0",
               $signed(outData[0]), $signed(outData[7]), $signed(outData[1]));
    end
    take_result();
    checks++;
    if ({done, busy, outValid} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL basic_done got=%b required=100", {done, busy, outValid});
    end
    doneSeen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done) doneSeen++;
    end
    checks++;
    if (doneSeen !== 0) begin
      failures++;
      $display("[TB] FAIL basic_done_once extra_pulses=%0d required=0", doneSeen);
    end
  endtask

  task automatic test_backpressure();
    logic [LANES-1:0][W-1:0] p;
    logic [W-1:0] exp0;
    logic [W-1:0] exp3;
    start_job(16'd2, 16'd3);
    for (int px = 0; px < 3; px++) begin
      p = '0; p[0] = 32'(10 * px + 1); p[3] = 32'(-1000 * (px + 1));
      send_beat(p);
      p = '0; p[0] = 32'(10 * px + 2); p[3] = 32'(-1000 * (px + 1));
      send_beat(p);
      exp0 = 32'(20 * px + 3);
      exp3 = 32'(-2000 * (px + 1));
      // Garbage partials during the stall must be ignored.
      inValid   = 1'b1;
      inPartial = {LANES{32'd999}};
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (outValid !== 1'b1 || inReady !== 1'b0 || outData[0] !== exp0 || outData[3] !== exp3
            || outLast !== (px == 2)) begin
          failures++;
          $display("[TB] FAIL bp_stall px=%0d v=%b rdy=%b last=%b d0=%0d d3=%0d required v=1 rdy=0 last=%b d0=%0d d3=%0d",
                   px, outValid, inReady, outLast, $signed(outData[0]), $signed(outData[3]),
                   (px == 2), $signed(exp0), $signed(exp3));
        end
        @(negedge clk);
      end
      inValid   = 1'b0;
      inPartial = '0;
      take_result();
      if (px < 2) begin
        checks++;
        if ({outValid, inReady, done} !== 3'b010) begin
          failures++;
          $display("[TB] FAIL bp_return_accum px=%0d got=%b required=010", px, {outValid, inReady, done});
        end
      end else begin
        checks++;
        if ({done, busy} !== 2'b10) begin
          failures++;
          $display("[TB] FAIL bp_done got=%b required=10", {done, busy});
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic [LANES-1:0][W-1:0] p;
    start_job(16'd2, 16'd1);
    p = '0; p[0] = 32'h7FFF_FFF0; p[1] = 32'h8000_0010; p[2] = 32'd7;
    send_beat(p);
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sat_ovf_early got=%b required=0", ovf);
    end
    p = '0; p[0] = 32'h0000_0100; p[1] = 32'hFFFF_FF00; p[2] = 32'd8;
    send_beat(p);
    checks++;
    if (outData[0] !== 32'h7FFF_FFFF || outData[1] !== 32'h8000_0000 || outData[2] !== 32'd15) begin
      failures++;
      $display("[TB] FAIL sat_data got=%h/%h/%h required=7fffffff/80000000/0000000f",
               outData[0], outData[1], outData[2]);
    end
    checks++;
    if (ovf !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sat_ovf got=%b required=1", ovf);
    end
    take_result();
    checks++;
    if (ovf !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sat_ovf_sticky got=%b required=1", ovf);
    end
    start_job(16'd1, 16'd1);
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sat_ovf_clear got=%b required=0", ovf);
    end
    p = '0; p[0] = 32'd1;
    send_beat(p);
    checks++;
    if (outData[0] !== 32'd1 || outData[1] !== 32'd0 || ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sat_next_job d0=%h d1=%h ovf=%b required=1/0/0", outData[0], outData[1], ovf);
    end
    take_result();
  endtask

  task automatic test_edge_counts();
    logic [LANES-1:0][W-1:0] p;
    int busySeen;
    start_job(16'd0, 16'd2);
    p = '0; p[0] = 32'd7;
    send_beat(p);
    checks++;
    if (outValid !== 1'b1 || outLast !== 1'b0 || outData[0] !== 32'd7) begin
      failures++;
      $display("[TB] FAIL tiles0_pix0 v=%b last=%b d0=%0d required 1/0/7", outValid, outLast, outData[0]);
    end
    take_result();
    p = '0; p[0] = 32'd9;
    send_beat(p);
    checks++;
    if (outValid !== 1'b1 || outLast !== 1'b1 || outData[0] !== 32'd9) begin
      failures++;
      $display("[TB] FAIL tiles0_pix1 v=%b last=%b d0=%0d required 1/1/9", outValid, outLast, outData[0]);
    end
    take_result();
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL tiles0_done got=%b required=1", done);
    end
    @(negedge clk);
    start_job(16'd3, 16'd0);
    checks++;
    if ({done, busy, inReady} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL pix0_done got=%b required=100", {done, busy, inReady});
    end
    busySeen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (busy || done) busySeen++;
    end
    checks++;
    if (busySeen !== 0) begin
      failures++;
      $display("[TB] FAIL pix0_quiet busy_or_done_cycles=%0d required=0", busySeen);
    end
  endtask

  task automatic test_mid_job();
    logic [LANES-1:0][W-1:0] p;
    int badSeen;
    start_job(16'd3, 16'd1);
    p = '0; p[0] = 32'd4;
    send_beat(p);
    // Start during ACCUM with a different configuration must be ignored.
    start    = 1'b1;
    numTiles = 16'd1;
    numPix   = 16'd5;
    @(negedge clk);
    start    = 1'b0;
    numTiles = 16'd0;
    numPix   = 16'd0;
    p = '0; p[0] = 32'd5;
    send_beat(p);
    checks++;
    if (outValid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midstart_ignored v=%b busy=%b required 0/1", outValid, busy);
    end
    p = '0; p[0] = 32'd6;
    send_beat(p);
    checks++;
    if (outValid !== 1'b1 || outLast !== 1'b1 || outData[0] !== 32'd15) begin
      failures++;
      $display("[TB] FAIL midstart_result v=%b last=%b d0=%0d required 1/1/15", outValid, outLast, outData[0]);
    end
    take_result();
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midstart_done got=%b required=1", done);
    end
    @(negedge clk);

    // Reset in EMIT with ovf set and non-zero result held.
    start_job(16'd2, 16'd2);
    p = '0; p[0] = 32'd3; p[5] = 32'h7FFF_FFFF;
    send_beat(p);
    p = '0; p[0] = 32'd4; p[5] = 32'd1;
    send_beat(p);
    checks++;
    if (outValid !== 1'b1 || ovf !== 1'b1 || outData[0] !== 32'd7) begin
      failures++;
      $display("[TB] FAIL prereset_emit v=%b ovf=%b d0=%0d required 1/1/7", outValid, ovf, outData[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, inReady, outValid, outLast, done, ovf} !== 6'b0 || outData !== '0) begin
      failures++;
      $display("[TB] FAIL async_reset flags=%b data=%h required flags=000000 data=0",
               {busy, inReady, outValid, outLast, done, ovf}, outData);
    end
    @(negedge clk);
    rst_n = 1'b1;
    badSeen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done || busy) badSeen++;
    end
    checks++;
    if (badSeen !== 0) begin
      failures++;
      $display("[TB] FAIL postreset_idle done_or_busy_cycles=%0d required=0", badSeen);
    end
    start_job(16'd1, 16'd1);
    p = '0; p[0] = 32'd42;
    send_beat(p);
    checks++;
    if (outValid !== 1'b1 || outData[0] !== 32'd42 || outData[5] !== 32'd0 || ovf !== 1'b0) begin
      failures++;
      $display("[TB] FAIL postreset_job v=%b d0=%0d d5=%h ovf=%b required 1/42/0/0",
               outValid, outData[0], outData[5], ovf);
    end
    take_result();
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL postreset_done got=%b required=1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    longint acc [LANES];
    logic [LANES-1:0][W-1:0] expVec;
    logic [LANES-1:0][W-1:0] p;
    logic [W-1:0] v;
    longint s;
    int tiles, eff, pix, beatIdx, pixIdx, cyc;
    bit jobDone, haveExp;
    for (int job = 0; job < 100; job++) begin
      tiles = $urandom_range(0, 4);
      pix   = $urandom_range(1, 3);
      eff   = (tiles == 0) ? 1 : tiles;
      start_job(CW'(tiles), CW'(pix));
      for (int l = 0; l < LANES; l++) acc[l] = 0;
      expVec  = '0;
      beatIdx = 0;
      pixIdx  = 0;
      cyc     = 0;
      jobDone = 0;
      haveExp = 0;
      while (!jobDone && cyc < 1000) begin
        inValid  = ($urandom_range(0, 3) != 0);
        outReady = ($urandom_range(0, 3) != 0);
        for (int l = 0; l < LANES; l++) begin
          if ($urandom_range(0, 15) == 0) v = $urandom;
          else v = 32'($urandom_range(0, 4000)) - 32'd2000;
          p[l] = v;
        end
        inPartial = p;
        if (inValid && inReady) begin
          for (int l = 0; l < LANES; l++) begin
            s = acc[l] + longint'($signed(p[l]));
            if (s > 64'sd2147483647) s = 64'sd2147483647;
            if (s < -64'sd2147483648) s = -64'sd2147483648;
            acc[l] = s;
          end
          beatIdx++;
          if (beatIdx == eff) begin
            for (int l = 0; l < LANES; l++) begin
              expVec[l] = acc[l][31:0];
              acc[l] = 0;
            end
            beatIdx = 0;
            haveExp = 1;
          end
        end else if (outReady && outValid) begin
          checks++;
          if (!haveExp || outData !== expVec || outLast !== (pixIdx == pix - 1)) begin
            failures++;
            $display("[TB] FAIL rand_result job=%0d pix=%0d have=%0b last=%b got=%h required=%h",
                     job, pixIdx, haveExp, outLast, outData, expVec);
          end
          haveExp = 0;
          pixIdx++;
          if (pixIdx == pix) jobDone = 1;
        end
        @(negedge clk);
        cyc++;
      end
      inValid   = 1'b0;
      outReady  = 1'b0;
      inPartial = '0;
      checks++;
      if (!jobDone || done !== 1'b1) begin
        failures++;
        $display("[TB] FAIL rand_job_end job=%0d finished=%0b done=%b required 1/1", job, jobDone, done);
      end
      if (!jobDone) break;
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    numTiles  = '0;
    numPix    = '0;
    inValid   = 1'b0;
    outReady  = 1'b0;
    inPartial = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_saturation();
    test_edge_counts();
    test_mid_job();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
